pcihellocore_pio_ext: RTL and testbench

Parametrised Avalon-MM general-purpose I/O slave for the PCI hello core, driving the board LEDs and reading switches/keys. It provides an output register with atomic bit-set/bit-clear, hardware-timed auto-clearing pulses, and an optional synchronised input port with edge capture and a level interrupt. It sits on the core's Avalon-MM interconnect behind the PCIe bridge, one instance per I/O bank.

---
 rtl/pcihellocore_pio_ext.sv | 151 +++++++++++++++
 tb/tb_pcihellocore_pio_ext.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pcihellocore_pio_ext.sv
// Avalon-MM GPIO slave: output register with set/clear/auto-clearing pulses.
// Define PIO_EDGE_IRQ_EN to build the synchronised input, edge capture and irq.
module pcihellocore_pio_ext #(
    parameter int unsigned      WIDTH       = 18,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    localparam int unsigned PLW     = 16;
    localparam logic [2:0]  A_DATA  = 3'd0;
    localparam logic [2:0]  A_SET   = 3'd4;
    localparam logic [2:0]  A_CLR   = 3'd5;
    localparam logic [2:0]  A_PLEN  = 3'd6;
    localparam logic [2:0]  A_PULSE = 3'd7;

    logic             wr_c, rd_c, expire_c;
    logic [WIDTH-1:0] wd_c;
    logic [PLW-1:0]   plen_eff_c;

    logic [WIDTH-1:0] data_q, data_d, pmask_q, pmask_d;
    logic [PLW-1:0]   plen_q, plen_d, cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;

    assign wr_c       = chipselect & ~write_n;
    assign rd_c       = chipselect & ~read_n;
    assign wd_c       = writedata[WIDTH-1:0];
    assign plen_eff_c = (plen_q == '0) ? PLW'(1) : plen_q;
    assign expire_c   = (cnt_q == PLW'(1));

    logic unused_wd;
    assign unused_wd = &{1'b0, writedata};

`ifdef PIO_EDGE_IRQ_EN
    localparam logic [2:0] A_IN   = 3'd1;
    localparam logic [2:0] A_MASK = 3'd2;
    localparam logic [2:0] A_EDGE = 3'd3;

    logic [WIDTH-1:0] s0_q, s1_q, prev_q, mask_q, mask_d, edge_q, edge_d, det_c;

    // Edge detection on the synchronised input against its one-cycle history.
    always_comb begin
        det_c = s1_q ^ prev_q;
        if (EDGE_TYPE == 0)      det_c = s1_q & ~prev_q;
        else if (EDGE_TYPE == 1) det_c = ~s1_q & prev_q;
    end

    // A newly detected edge wins over a simultaneous W1C of the same bit.
    always_comb begin
        mask_d = mask_q;
        edge_d = edge_q;
        if (wr_c && address == A_MASK) mask_d = wd_c;
        if (wr_c && address == A_EDGE) edge_d = edge_q & ~wd_c;
        edge_d = edge_d | det_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_q   <= '0;
            s1_q   <= '0;
            prev_q <= '0;
            mask_q <= '0;
            edge_q <= '0;
        end else begin
            s0_q   <= in_port;
            s1_q   <= s0_q;
            prev_q <= s1_q;
            mask_q <= mask_d;
            edge_q <= edge_d;
        end
    end

    assign irq = |(edge_q & mask_q);
`else
    logic unused_in;
    assign unused_in = &{1'b0, in_port, 32'(EDGE_TYPE)};
    assign irq       = 1'b0;
`endif

    // Pulse expiry is applied first so bus writes to the same bits override it.
    always_comb begin
        data_d  = data_q;
        pmask_d = pmask_q;
        cnt_d   = cnt_q;
        plen_d  = plen_q;
        rdata_d = rdata_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - PLW'(1);
            if (expire_c) begin
                data_d  = data_q & ~pmask_q;
                pmask_d = '0;
            end
        end
        if (wr_c) begin
            case (address)
                A_DATA:  data_d = wd_c;
                A_SET:   data_d = data_d | wd_c;
                A_CLR:   data_d = data_d & ~wd_c;
                A_PLEN:  plen_d = writedata[PLW-1:0];
                A_PULSE: begin
                    data_d  = data_q | wd_c;
                    pmask_d = pmask_q | wd_c;
                    cnt_d   = plen_eff_c;
                end
                default: ;
            endcase
        end
        if (rd_c) begin
            case (address)
                A_DATA:  rdata_d = 32'(data_q);
                A_PLEN:  rdata_d = 32'(plen_q);
                A_PULSE: rdata_d = 32'(pmask_q);
`ifdef PIO_EDGE_IRQ_EN
                A_IN:    rdata_d = 32'(s1_q);
                A_MASK:  rdata_d = 32'(mask_q);
                A_EDGE:  rdata_d = 32'(edge_q);
`endif
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= RESET_VALUE;
            pmask_q <= '0;
            cnt_q   <= '0;
            plen_q  <= PLW'(1);
            rdata_q <= '0;
        end else begin
            data_q  <= data_d;
            pmask_q <= pmask_d;
            cnt_q   <= cnt_d;
            plen_q  <= plen_d;
            rdata_q <= rdata_d;
        end
    end

    assign out_port = data_q;
    assign readdata = rdata_q;
endmodule

// File: tb/tb_pcihellocore_pio_ext.sv
// Directed bench for pcihellocore_pio_ext; read results are checked through an expectation queue.
module tb_pcihellocore_pio_ext;
    localparam int unsigned WIDTH = 18;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [2:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic             read_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;
    logic [WIDTH-1:0] in_port = '0;
    logic             irq;

    int ncomp = 0;
    int nfail = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    pcihellocore_pio_ext #(
        .WIDTH(WIDTH), .RESET_VALUE(18'h00A5), .EDGE_TYPE(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        string       t;
        @(negedge clk);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        chipselect = 1'b0; read_n = 1'b1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, readdata, e);
        end
    endtask

    initial begin
        // Reset state
        cycles(3);
        chk("rst_out", 32'(out_port), 32'h00A5);
        chk("rst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(3'd6, 32'h1, "rst_plen");
        bus_read(3'd0, 32'h00A5, "rst_data");

        // Width masking, set and clear
        bus_write(3'd0, 32'hFFFF_FFFF);
        chk("data_all", 32'(out_port), 32'h3FFFF);
        bus_read(3'd0, 32'h0003_FFFF, "rd_data_all");
        bus_write(3'd5, 32'h3);
        chk("outclr", 32'(out_port), 32'h3FFFC);
        bus_write(3'd4, 32'h1);
        chk("outset", 32'(out_port), 32'h3FFFD);
        bus_read(3'd4, 32'h0, "rd_outset");

        // Single pulse of 5 cycles
        bus_write(3'd6, 32'd5);
        bus_write(3'd0, 32'h0);
        bus_write(3'd7, 32'h10);
        chk("pulse_t0", 32'(out_port), 32'h10);
        for (int k = 1; k <= 5; k++) begin
            cycles(1);
            chk($sformatf("pulse_t%0d", k), 32'(out_port), (k < 5) ? 32'h10 : 32'h0);
        end

        // Second pulse at cycle 3 restarts and extends
        bus_write(3'd7, 32'h10);
        cycles(2);
        bus_write(3'd7, 32'h20);
        chk("ext_t3", 32'(out_port), 32'h30);
        bus_read(3'd7, 32'h30, "rd_pmask");
        chk("ext_t4", 32'(out_port), 32'h30);
        for (int k = 5; k <= 8; k++) begin
            cycles(1);
            chk($sformatf("ext_t%0d", k), 32'(out_port), (k < 8) ? 32'h30 : 32'h0);
        end
        bus_read(3'd7, 32'h0, "rd_pmask_done");

        // OUTSET at the expiry edge keeps its bit
        bus_write(3'd6, 32'd2);
        bus_write(3'd7, 32'h1);
        cycles(1);
        bus_write(3'd4, 32'h1);
        chk("set_vs_expire", 32'(out_port), 32'h1);
        cycles(2);
        chk("set_vs_expire_hold", 32'(out_port), 32'h1);

        // PULSE_LEN of 0 behaves as 1
        bus_write(3'd6, 32'd0);
        bus_write(3'd7, 32'h4);
        chk("plen0_t0", 32'(out_port), 32'h5);
        cycles(1);
        chk("plen0_t1", 32'(out_port), 32'h1);

        // Reset aborts an active pulse
        bus_write(3'd6, 32'd100);
        bus_write(3'd7, 32'h8);
        cycles(3);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_out", 32'(out_port), 32'h00A5);
        @(negedge clk);
        reset_n = 1'b1;
        bus_write(3'd4, 32'h8);
        cycles(105);
        chk("no_spurious_clear", 32'(out_port), 32'h00AD);
        bus_read(3'd7, 32'h0, "rst_pmask");
        bus_read(3'd6, 32'h1, "rst_plen2");

`ifdef PIO_EDGE_IRQ_EN
        // Rising edge capture and irq
        bus_write(3'd2, 32'h1);
        bus_read(3'd2, 32'h1, "rd_irqmask");
        @(negedge clk);
        in_port[0] = 1'b1;
        cycles(1);
        chk("edge_k0_irq", 32'(irq), 32'h0);
        cycles(1);
        chk("edge_k1_irq", 32'(irq), 32'h0);
        cycles(1);
        chk("edge_k2_irq", 32'(irq), 32'h1);
        bus_read(3'd3, 32'h1, "rd_edge");
        bus_read(3'd1, 32'h1, "rd_in");
        bus_write(3'd3, 32'h1);
        chk("w1c_irq", 32'(irq), 32'h0);
        // Falling edge is ignored in rising mode
        @(negedge clk);
        in_port[0] = 1'b0;
        cycles(4);
        chk("fall_ignored", 32'(irq), 32'h0);
        // W1C coinciding with a new edge
        @(negedge clk);
        in_port[0] = 1'b1;
        cycles(2);
        bus_write(3'd3, 32'h1);
        chk("w1c_vs_edge_irq", 32'(irq), 32'h1);
        bus_read(3'd3, 32'h1, "w1c_vs_edge_rd");
`else
        // Input features absent
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_port = ~in_port;
            cycles(1);
        end
        bus_write(3'd2, 32'hFFFF_FFFF);
        bus_write(3'd3, 32'hFFFF_FFFF);
        bus_write(3'd1, 32'hFFFF_FFFF);
        bus_read(3'd1, 32'h0, "noirq_rd1");
        bus_read(3'd2, 32'h0, "noirq_rd2");
        bus_read(3'd3, 32'h0, "noirq_rd3");
        chk("noirq_irq", 32'(irq), 32'h0);
        chk("noirq_out", 32'(out_port), 32'h00AD);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
